// File: rtl/ex_fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard controller.
// Keeps a shadow copy of destination info for EX, MEM and WB. It computes the
// ALU operand mux selects when an instruction issues from ID and registers them
// so they are valid while that instruction sits in EX. When a load is in EX and
// the ID instruction needs its result, ID stalls for one cycle and a bubble
// enters EX. A saturating counter records how many cycles stalled.
module ex_fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_alu_imm,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, dst: '0, reg_write: 1'b0, mem_read: 1'b0};

  stage_t ex_stage;
  stage_t mem_stage;
  stage_t wb_stage;

  stage_t     issue_stage;
  logic       issue;
  logic       load_hit;
  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;

  // A stage can supply register r only if it is a real instruction that writes
  // r, and r is not the hard-wired zero register.
  function automatic logic produces(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.dst == r) & (r != '0);
  endfunction

  // Youngest producer wins: EX/MEM result before MEM/WB write-back data.
  function automatic logic [1:0] fwd_sel(input stage_t ex_s, input stage_t mem_s,
                                         input logic [REG_AW-1:0] r);
    if (produces(ex_s, r))
      return SEL_EXM;
    else if (produces(mem_s, r))
      return SEL_MWB;
    else
      return SEL_RF;
  endfunction

  // Load-use detection and the instruction that enters EX on the next edge;
  // a flush always overrides a stall so a squashed instruction never stalls.
  always_comb begin
    load_hit = ex_stage.valid & ex_stage.mem_read & (ex_stage.dst != '0) &
               ((id_use_rs & (id_rs == ex_stage.dst)) |
                (id_use_rt & ~id_alu_imm & (id_rt == ex_stage.dst)));
    stall    = ~ex_flush & id_valid & load_hit;
    issue    = id_valid & ~stall & ~ex_flush;

    issue_stage = BUBBLE;
    sel_a_next  = SEL_RF;
    sel_b_next  = SEL_RF;
    if (issue) begin
      issue_stage.valid     = 1'b1;
      issue_stage.dst       = id_dst;
      issue_stage.reg_write = id_reg_write;
      issue_stage.mem_read  = id_mem_read;
      if (id_use_rs)
        sel_a_next = fwd_sel(ex_stage, mem_stage, id_rs);
      if (id_alu_imm)
        sel_b_next = SEL_IMM;
      else if (id_use_rt)
        sel_b_next = fwd_sel(ex_stage, mem_stage, id_rt);
    end
  end

  // Advance the shadow pipeline and register the selects for the issuing
  // instruction so they line up with it while it is in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_stage  <= BUBBLE;
      mem_stage <= BUBBLE;
      wb_stage  <= BUBBLE;
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      wb_stage  <= mem_stage;
      mem_stage <= ex_stage;
      ex_stage  <= issue_stage;
      fwd_a_sel <= sel_a_next;
      fwd_b_sel <= sel_b_next;
    end
  end

  // Count stalled cycles, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
